// File: rtl/divider_sequential.sv
// Multi-cycle unsigned restoring divider with valid/ready handshakes on both sides.
// Produces one quotient bit per clock, MSB first.
module divider_sequential #(
    parameter int unsigned DIVIDEND_WIDTH = 4,
    parameter int unsigned DIVISOR_WIDTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    localparam int unsigned CW = (DIVIDEND_WIDTH > 1) ? $clog2(DIVIDEND_WIDTH) : 1;
    localparam logic [CW-1:0] LastBit = CW'(DIVIDEND_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t                    r_state;
    logic [CW-1:0]             r_count;
    logic [DIVIDEND_WIDTH-1:0] r_work;
    logic [DIVISOR_WIDTH-1:0]  r_partial;
    logic [DIVISOR_WIDTH-1:0]  r_divisor;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [DIVIDEND_WIDTH-1:0] r_quotient;
    logic [DIVISOR_WIDTH-1:0]  r_remainder;
    logic                      r_dbz;

    logic [DIVISOR_WIDTH:0]    w_p;
    logic                      w_qbit;
    logic [DIVISOR_WIDTH-1:0]  w_diff;
    logic [DIVISOR_WIDTH-1:0]  w_partial_nxt;
    logic [DIVIDEND_WIDTH-1:0] w_work_nxt;

    // r_work shifts dividend bits out of the MSB while quotient bits enter at the LSB.
    always_comb begin
        w_p           = {r_partial, r_work[DIVIDEND_WIDTH-1]};
        w_qbit        = (w_p >= {1'b0, r_divisor});
        // When w_qbit is set the difference is below the divisor, so the low bits suffice.
        w_diff        = w_p[DIVISOR_WIDTH-1:0] - r_divisor;
        w_partial_nxt = w_qbit ? w_diff : w_p[DIVISOR_WIDTH-1:0];
        w_work_nxt    = {r_work[DIVIDEND_WIDTH-2:0], w_qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_work      <= '0;
            r_partial   <= '0;
            r_divisor   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        r_work     <= dividend;
                        r_divisor  <= divisor;
                        r_partial  <= '0;
                        r_count    <= LastBit;
                        if (divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= '0;
                            r_dbz       <= 1'b1;
                            r_state     <= StDone;
                        end else begin
                            r_state <= StRun;
                        end
                    end
                end
                StRun: begin
                    r_work    <= w_work_nxt;
                    r_partial <= w_partial_nxt;
                    r_count   <= r_count - 1'b1;
                    if (r_count == '0) begin
                        r_quotient  <= w_work_nxt;
                        r_remainder <= w_partial_nxt;
                        r_dbz       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    // Divide-by-zero enters here with out_valid still low; raise it one edge later.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_sequential.sv
// Directed, table-driven bench for divider_sequential plus hand-written corner sequences.
module tb_divider_sequential;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] dividend;
    logic [1:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] quotient;
    logic [1:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    divider_sequential #(
        .DIVIDEND_WIDTH(4),
        .DIVISOR_WIDTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dvd;
        logic [1:0] dvs;
        logic [3:0] q;
        logic [1:0] r;
        logic       z;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present operands, wait for in_ready, and return #1 after the accept edge.
    task automatic accept(input logic [3:0] a, input logic [1:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = ~b;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    vec_t vecs[10];
    int   lat;

    initial begin
        vecs[0] = '{dvd: 4'd9,  dvs: 2'd2, q: 4'd4,  r: 2'd1, z: 1'b0, lat: 4};
        vecs[1] = '{dvd: 4'd11, dvs: 2'd3, q: 4'd3,  r: 2'd2, z: 1'b0, lat: 4};
        vecs[2] = '{dvd: 4'd15, dvs: 2'd1, q: 4'd15, r: 2'd0, z: 1'b0, lat: 4};
        vecs[3] = '{dvd: 4'd7,  dvs: 2'd0, q: 4'hF,  r: 2'd0, z: 1'b1, lat: 1};
        vecs[4] = '{dvd: 4'd0,  dvs: 2'd3, q: 4'd0,  r: 2'd0, z: 1'b0, lat: 4};
        vecs[5] = '{dvd: 4'd2,  dvs: 2'd3, q: 4'd0,  r: 2'd2, z: 1'b0, lat: 4};
        vecs[6] = '{dvd: 4'd15, dvs: 2'd3, q: 4'd5,  r: 2'd0, z: 1'b0, lat: 4};
        vecs[7] = '{dvd: 4'd14, dvs: 2'd3, q: 4'd4,  r: 2'd2, z: 1'b0, lat: 4};
        vecs[8] = '{dvd: 4'd12, dvs: 2'd2, q: 4'd6,  r: 2'd0, z: 1'b0, lat: 4};
        vecs[9] = '{dvd: 4'd0,  dvs: 2'd0, q: 4'hF,  r: 2'd0, z: 1'b1, lat: 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_quotient",  32'(quotient),    32'd0);
        chk("rst_remainder", 32'(remainder),   32'd0);
        chk("rst_dbz",       32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            accept(vecs[i].dvd, vecs[i].dvs);
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            wait_out(lat);
            chk("vec_latency",  32'(lat),         32'(vecs[i].lat));
            chk("vec_quotient", 32'(quotient),    32'(vecs[i].q));
            chk("vec_remainder",32'(remainder),   32'(vecs[i].r));
            chk("vec_dbz",      32'(div_by_zero), 32'(vecs[i].z));
            @(posedge clk); #1;
            chk("vec_release_valid", 32'(out_valid), 32'd0);
            chk("vec_release_ready", 32'(in_ready),  32'd1);
        end

        // Exhaustive sweep of non-zero divisors.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 4; b++) begin
                accept(4'(a), 2'(b));
                wait_out(lat);
                chk("sweep_qdr", 32'(int'(quotient) * b + int'(remainder)), 32'(a));
                chk("sweep_rem_lt", 32'(int'(remainder) < b), 32'd1);
                @(posedge clk); #1;
            end
        end

        // Backpressure: result held stable while out_ready is low.
        out_ready = 1'b0;
        accept(4'd6, 2'd3);
        wait_out(lat);
        for (int c = 0; c < 5; c++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_quotient",  32'(quotient),  32'd2);
            chk("bp_remainder", 32'(remainder), 32'd0);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready),  32'd1);

        // Reset asserted mid-run discards the division.
        accept(4'd13, 2'd2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid),   32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),    32'd1);
        chk("mid_rst_quotient",  32'(quotient),    32'd0);
        chk("mid_rst_remainder", 32'(remainder),   32'd0);
        chk("mid_rst_dbz",       32'(div_by_zero), 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("mid_rst_no_output", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        accept(4'd13, 2'd2);
        wait_out(lat);
        chk("post_rst_quotient",  32'(quotient),  32'd6);
        chk("post_rst_remainder", 32'(remainder), 32'd1);
        @(posedge clk); #1;

        // New operands while busy are ignored.
        out_ready = 1'b0;
        accept(4'd9, 2'd2);
        in_valid = 1'b1;
        dividend = 4'd3;
        divisor  = 2'd1;
        wait_out(lat);
        chk("busy_latency", 32'(lat), 32'd4);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("busy_quotient",  32'(quotient),  32'd4);
        chk("busy_remainder", 32'(remainder), 32'd1);
        chk("busy_in_ready",  32'(in_ready),  32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("busy_release_ready", 32'(in_ready), 32'd1);
        repeat (6) begin
            @(posedge clk); #1;
            chk("busy_no_extra_result", 32'(out_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
